// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-port (CPU / loader) arbiter and sequencer for the unified
//            instruction/data memory. It issues one access at a time, paces
//            it to the fixed memory read latency and returns per-port done
//            pulses with registered read data.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1    // legal range 1..15
) (
  input  logic          clk,
  input  logic          reset,    // synchronous, active-low

  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic [DW-1:0] c_rdata,
  output logic          c_done,
  output logic          c_stall,

  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,

  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,

  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    CAPT  = 2'd3
  } state_t;

  // Counter preload: remaining cycles between ISSUE and CAPT
  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t     state;
  logic [3:0] lat_cnt;
  logic       last_grant;   // 0 = CPU, 1 = loader
  logic       acc_we;       // latched write flag, kept for the CAPT decision

  logic       c_elig;
  logic       d_elig;
  logic       grant_d;
  logic       any_elig;

  // A port whose done pulse is high this cycle is masked so it cannot be
  // re-granted before it has seen its completion.
  assign c_elig   = c_req & ~c_done;
  assign d_elig   = d_req & ~d_done;
  assign any_elig = c_elig | d_elig;
  // Loader wins when it is the only eligible port, or on a tie when the CPU
  // was granted last.
  assign grant_d  = d_elig & (~c_elig | ~last_grant);

  // Stall the CPU decoder from request until its completion pulse
  assign c_stall  = c_req & ~c_done;

  // Arbitration / sequencing FSM with registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      lat_cnt    <= 4'd0;
      last_grant <= 1'b1;
      acc_we     <= 1'b0;
      owner      <= 1'b0;
      busy       <= 1'b0;
      m_en       <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      c_rdata    <= '0;
      d_rdata    <= '0;
      c_done     <= 1'b0;
      d_done     <= 1'b0;
    end else begin
      c_done <= 1'b0;
      d_done <= 1'b0;
      m_en   <= 1'b0;
      m_we   <= 1'b0;
      case (state)
        IDLE: begin
          if (any_elig) begin
            owner   <= grant_d;
            acc_we  <= grant_d ? d_we    : c_we;
            m_we    <= grant_d ? d_we    : c_we;
            m_addr  <= grant_d ? d_addr  : c_addr;
            m_wdata <= grant_d ? d_wdata : c_wdata;
            m_en    <= 1'b1;
            busy    <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          lat_cnt <= LAT_M1;
          state   <= (MEM_LAT > 1) ? WAIT : CAPT;
        end
        WAIT: begin
          lat_cnt <= lat_cnt - 4'd1;
          if (lat_cnt == 4'd1) begin
            state <= CAPT;
          end
        end
        CAPT: begin
          if (!acc_we) begin
            if (owner) d_rdata <= m_rdata;
            else       c_rdata <= m_rdata;
          end
          if (owner) d_done <= 1'b1;
          else       c_done <= 1'b1;
          last_grant <= owner;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
